// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the shared FIFO: issues reads, captures the registered
// FIFO data one cycle later into a 2-entry buffer, and streams words out valid/ready.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  idle
);

  // Handshake: a word transfers on any posedge where m_valid & m_ready; while
  // m_valid & ~m_ready, m_valid and m_data hold until accepted.

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pop;

  // occ + inflight never exceeds 2, so the 2-bit sum cannot overflow, and pop
  // implies occ >= 1 so the subtraction cannot underflow.
  always_comb begin
    pop        = m_valid & m_ready;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    fifo_rd_en = ~rst & en & ~fifo_empty & (occ_d < 2'd2);
  end

  always_comb begin
    m_valid    = ~rst & (occ_q != 2'd0);
    m_data     = rst ? '0 : buf_q[rd_ptr_q];
    idle       = rst | ((occ_q == 2'd0) & ~inflight_q);
    word_count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      // The read issued last cycle always has a free slot to land in.
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_data_out;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule
